// File: rtl/mag_approx_multi.sv
`default_nettype none
// ============================================================================
// Module      : mag_approx_multi
// Description : Pipelined, multi-channel alpha-max-beta-min magnitude
//               estimator with per-sample coefficient mode, configurable
//               latency, saturating output and per-channel peak-hold
//               registers with a read-and-clear port.
//
// Ports       : Clk, Rst_n          clock, asynchronous active-low reset
//               Input_valid/index/mode/i/q
//                                   sample strobe, channel tag, coefficient
//                                   mode and signed I/Q sample
//               Output_valid/index/data/saturated
//                                   result strobe, delayed tag, magnitude,
//                                   clamp flag (held while Output_valid=0)
//               Peak_req/index      peak read-and-clear request
//               Peak_valid/data     peak read response, one cycle later
//               Sat_count           saturated-result counter
//
// Options     : MAG_APPROX_SAT_COUNT_EN -- when defined, Sat_count counts
//               saturated results (sticks at 0xFFFF, cleared by a peak read
//               of channel 0). When undefined Sat_count is tied to 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mag_approx_multi #(
   parameter int DATA_WIDTH   = 14,
   parameter int OUTPUT_WIDTH = 14,
   parameter int NUM_CHANNELS = 8,
   parameter int LATENCY      = 3,
   parameter int CHAN_WIDTH   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                         Clk,
   input  logic                         Rst_n,
   input  logic                         Input_valid,
   input  logic [CHAN_WIDTH-1:0]        Input_index,
   input  logic [1:0]                   Input_mode,
   input  logic signed [DATA_WIDTH-1:0] Input_i,
   input  logic signed [DATA_WIDTH-1:0] Input_q,
   output logic                         Output_valid,
   output logic [CHAN_WIDTH-1:0]        Output_index,
   output logic [OUTPUT_WIDTH-1:0]      Output_data,
   output logic                         Output_saturated,
   input  logic                         Peak_req,
   input  logic [CHAN_WIDTH-1:0]        Peak_index,
   output logic                         Peak_valid,
   output logic [OUTPUT_WIDTH-1:0]      Peak_data,
   output logic [15:0]                  Sat_count
);

   // Magnitudes never exceed 2^(DATA_WIDTH-1)-1, so DATA_WIDTH-1 bits hold
   // them. Products (7*vmax) need a few guard bits before the shift; the
   // final sums always fit in DATA_WIDTH+1 bits.
   localparam int c_abs_w  = DATA_WIDTH - 1;
   localparam int c_prod_w = DATA_WIDTH + 3;
   localparam int c_extra  = LATENCY - 3;
   localparam logic [c_prod_w-1:0] c_sat_max =
      (c_prod_w'(1) << OUTPUT_WIDTH) - c_prod_w'(1);

   // |x| with the most negative code clamped to the most positive one.
   function automatic logic [c_abs_w-1:0] abs_clamp(
      input logic signed [DATA_WIDTH-1:0] x
   );
      logic [DATA_WIDTH-1:0] neg;
      neg = -x;
      if (!x[DATA_WIDTH-1])
         return x[c_abs_w-1:0];
      else if (x == {1'b1, {(DATA_WIDTH-1){1'b0}}})
         return '1;
      else
         return neg[c_abs_w-1:0];
   endfunction

   // ---------------------------------------------------------------- stages
   logic                    r_s1_valid;
   logic [CHAN_WIDTH-1:0]   r_s1_idx;
   logic [1:0]              r_s1_mode;
   logic [c_abs_w-1:0]      r_s1_abs_i;
   logic [c_abs_w-1:0]      r_s1_abs_q;

   logic                    r_s2_valid;
   logic [CHAN_WIDTH-1:0]   r_s2_idx;
   logic [1:0]              r_s2_mode;
   logic [c_abs_w-1:0]      r_s2_vmax;
   logic [c_abs_w-1:0]      r_s2_vmin;

   logic                    r_s3_valid;
   logic [CHAN_WIDTH-1:0]   r_s3_idx;
   logic [OUTPUT_WIDTH-1:0] r_s3_data;
   logic                    r_s3_sat;

   logic [c_prod_w-1:0]     w_vmax_x;
   logic [c_prod_w-1:0]     w_vmin_x;
   logic [c_prod_w-1:0]     w_alt;
   logic [c_prod_w-1:0]     w_sum;
   logic                    w_sat;
   logic [OUTPUT_WIDTH-1:0] w_clamped;

   // Stage 3 combine; every division is a right shift after the multiply,
   // which floors for these non-negative operands.
   always_comb begin
      w_vmax_x = c_prod_w'(r_s2_vmax);
      w_vmin_x = c_prod_w'(r_s2_vmin);
      w_alt    = '0;
      w_sum    = '0;
      case (r_s2_mode)
         2'd0:    w_sum = w_vmax_x + ((w_vmin_x * c_prod_w'(3)) >> 3);
         2'd1:    w_sum = w_vmax_x + (w_vmin_x >> 1);
         2'd2:    w_sum = w_vmax_x + (w_vmin_x >> 2);
         default: begin
            w_alt = ((w_vmax_x * c_prod_w'(7)) >> 3) + (w_vmin_x >> 1);
            w_sum = (w_alt > w_vmax_x) ? w_alt : w_vmax_x;
         end
      endcase
      w_sat     = (w_sum > c_sat_max);
      w_clamped = w_sat ? c_sat_max[OUTPUT_WIDTH-1:0] : w_sum[OUTPUT_WIDTH-1:0];
   end

   // Valids always advance; payload registers load only with a valid sample
   // so the outputs hold their last value between results.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_idx   <= '0;
         r_s1_mode  <= '0;
         r_s1_abs_i <= '0;
         r_s1_abs_q <= '0;
         r_s2_valid <= 1'b0;
         r_s2_idx   <= '0;
         r_s2_mode  <= '0;
         r_s2_vmax  <= '0;
         r_s2_vmin  <= '0;
         r_s3_valid <= 1'b0;
         r_s3_idx   <= '0;
         r_s3_data  <= '0;
         r_s3_sat   <= 1'b0;
      end else begin
         r_s1_valid <= Input_valid;
         if (Input_valid) begin
            r_s1_idx   <= Input_index;
            r_s1_mode  <= Input_mode;
            r_s1_abs_i <= abs_clamp(Input_i);
            r_s1_abs_q <= abs_clamp(Input_q);
         end
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_idx  <= r_s1_idx;
            r_s2_mode <= r_s1_mode;
            r_s2_vmax <= (r_s1_abs_i >= r_s1_abs_q) ? r_s1_abs_i : r_s1_abs_q;
            r_s2_vmin <= (r_s1_abs_i >= r_s1_abs_q) ? r_s1_abs_q : r_s1_abs_i;
         end
         r_s3_valid <= r_s2_valid;
         if (r_s2_valid) begin
            r_s3_idx  <= r_s2_idx;
            r_s3_data <= w_clamped;
            r_s3_sat  <= w_sat;
         end
      end
   end

   // --------------------------------------------------- extra latency stages
   logic                    w_out_valid;
   logic [CHAN_WIDTH-1:0]   w_out_idx;
   logic [OUTPUT_WIDTH-1:0] w_out_data;
   logic                    w_out_sat;

   generate
      if (c_extra > 0) begin : g_delay
         logic [c_extra-1:0]                   r_d_valid;
         logic [c_extra-1:0][CHAN_WIDTH-1:0]   r_d_idx;
         logic [c_extra-1:0][OUTPUT_WIDTH-1:0] r_d_data;
         logic [c_extra-1:0]                   r_d_sat;

         always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
               r_d_valid <= '0;
               r_d_idx   <= '0;
               r_d_data  <= '0;
               r_d_sat   <= '0;
            end else begin
               r_d_valid[0] <= r_s3_valid;
               if (r_s3_valid) begin
                  r_d_idx[0]  <= r_s3_idx;
                  r_d_data[0] <= r_s3_data;
                  r_d_sat[0]  <= r_s3_sat;
               end
               for (int k = 1; k < c_extra; k++) begin
                  r_d_valid[k] <= r_d_valid[k-1];
                  if (r_d_valid[k-1]) begin
                     r_d_idx[k]  <= r_d_idx[k-1];
                     r_d_data[k] <= r_d_data[k-1];
                     r_d_sat[k]  <= r_d_sat[k-1];
                  end
               end
            end
         end

         assign w_out_valid = r_d_valid[c_extra-1];
         assign w_out_idx   = r_d_idx[c_extra-1];
         assign w_out_data  = r_d_data[c_extra-1];
         assign w_out_sat   = r_d_sat[c_extra-1];
      end else begin : g_no_delay
         assign w_out_valid = r_s3_valid;
         assign w_out_idx   = r_s3_idx;
         assign w_out_data  = r_s3_data;
         assign w_out_sat   = r_s3_sat;
      end
   endgenerate

   assign Output_valid     = w_out_valid;
   assign Output_index     = w_out_idx;
   assign Output_data      = w_out_data;
   assign Output_saturated = w_out_sat;

   // ------------------------------------------------------------- peak hold
   logic [NUM_CHANNELS-1:0][OUTPUT_WIDTH-1:0] w_peak;
   logic                                      w_peak_idx_ok;
   logic                                      r_peak_valid;
   logic [OUTPUT_WIDTH-1:0]                   r_peak_data;

   // A read-clear coinciding with an update on the same channel leaves the
   // new sample in the register, so no result is lost to the clear.
   generate
      for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_peak
         logic [OUTPUT_WIDTH-1:0] r_peak;
         logic                    w_upd;
         logic                    w_clr;

         assign w_upd = w_out_valid && (w_out_idx == CHAN_WIDTH'(ch));
         assign w_clr = Peak_req && (Peak_index == CHAN_WIDTH'(ch));

         always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
               r_peak <= '0;
            end else if (w_upd) begin
               if (w_clr || (w_out_data > r_peak))
                  r_peak <= w_out_data;
            end else if (w_clr) begin
               r_peak <= '0;
            end
         end

         assign w_peak[ch] = r_peak;
      end
   endgenerate

   assign w_peak_idx_ok = (int'(Peak_index) < NUM_CHANNELS);

   // Response carries the register value from before this cycle's update.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_peak_valid <= 1'b0;
         r_peak_data  <= '0;
      end else begin
         r_peak_valid <= Peak_req;
         if (Peak_req)
            r_peak_data <= w_peak_idx_ok ? w_peak[Peak_index] : '0;
      end
   end

   assign Peak_valid = r_peak_valid;
   assign Peak_data  = r_peak_data;

   // ----------------------------------------------------- saturation counter
`ifdef MAG_APPROX_SAT_COUNT_EN
   logic [15:0] r_sat_count;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_sat_count <= '0;
      end else if (Peak_req && (Peak_index == '0)) begin
         r_sat_count <= '0;
      end else if (w_out_valid && w_out_sat && (r_sat_count != 16'hFFFF)) begin
         r_sat_count <= r_sat_count + 16'd1;
      end
   end

   assign Sat_count = r_sat_count;
`else
   assign Sat_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: doc/mag_approx_multi.md
Name: mag_approx_multi

Overview:
- Pipelined, multi-channel successor to the single-mode alpha-max-beta-min magnitude block in the dsp library.
- Per-sample selectable coefficient mode, configurable latency and output width with saturation.
- Per-channel peak-hold registers with a read-and-clear port.
- Sits after channelizer or DDC outputs, feeding detectors and power meters.

Parameters:
- DATA_WIDTH, 14, signed I/Q input width.
- OUTPUT_WIDTH, 14, unsigned magnitude width (any value 8..DATA_WIDTH+1).
- NUM_CHANNELS, 8, number of channel tags and peak registers.
- LATENCY, 3, cycles from Input_valid to Output_valid; minimum 3.
- CHAN_WIDTH, max(1, clog2(NUM_CHANNELS)), channel index width.

Ports:
- Clk  in  1  clock
- Rst_n  in  1  asynchronous active-low reset
- Input_valid  in  1  sample strobe
- Input_index  in  CHAN_WIDTH  channel tag
- Input_mode  in  2  coefficient mode, sampled with Input_valid
- Input_i  in  DATA_WIDTH  signed I
- Input_q  in  DATA_WIDTH  signed Q
- Output_valid  out  1  result strobe
- Output_index  out  CHAN_WIDTH  channel tag, delayed
- Output_data  out  OUTPUT_WIDTH  magnitude
- Output_saturated  out  1  result was clamped
- Peak_req  in  1  peak read request
- Peak_index  in  CHAN_WIDTH  channel to read
- Peak_valid  out  1  peak read response
- Peak_data  out  OUTPUT_WIDTH  peak value
- Sat_count  out  16  saturation counter (optional feature)

Behaviour:
- Reset: Rst_n low asynchronously clears all pipeline valids, Output_valid, Peak_valid, Sat_count and all peak registers. Data outputs reset to 0.
- Streaming: no backpressure. Accepts one sample per cycle, back-to-back, any gap pattern.
- Stage 1: abs(I), abs(Q). -2^(DATA_WIDTH-1) clamps to 2^(DATA_WIDTH-1)-1. Mode and index are registered alongside.
- Stage 2: vmax = max(|I|,|Q|), vmin = min(|I|,|Q|).
- Stage 3 combine, all divisions floor (shift after multiply), computed at DATA_WIDTH+1 bits:
  - mode 0: vmax + (3*vmin)>>3
  - mode 1: vmax + vmin>>1
  - mode 2: vmax + vmin>>2
  - mode 3: max(vmax, (7*vmax)>>3 + vmin>>1)
- Saturation: a result above 2^OUTPUT_WIDTH-1 outputs 2^OUTPUT_WIDTH-1 with Output_saturated=1; otherwise Output_saturated=0.
- Latency: LATENCY-3 extra delay stages carry valid, index, data and saturated together. Latency is exactly LATENCY for every sample.
- Output qualification: Output_index, Output_data and Output_saturated are meaningful only when Output_valid=1. They hold their last value otherwise.
- Peak hold, updated on each Output_valid: peak[Output_index] = max(peak, Output_data).
- Peak read: Peak_req at cycle N gives Peak_valid=1 at N+1 with Peak_data = peak[Peak_index] as it stood before cycle N's update. That register is then cleared.
- Simultaneous read-clear and update on the same channel: the register becomes the new Output_data, not 0, and the response holds the pre-update value.
- Simultaneous read-clear and update on different channels: both take effect independently.
- Peak_req with Peak_index >= NUM_CHANNELS: Peak_valid=1, Peak_data=0, no state change.
- Output_valid with Output_index >= NUM_CHANNELS: output passes through, no peak update.
- Reset mid-stream: in-flight samples are discarded and no Output_valid follows. The first sample after Rst_n deasserts appears LATENCY cycles later.

Optional Feature:
- MAG_APPROX_SAT_COUNT_EN defined: Sat_count increments on each Output_valid with Output_saturated=1. It saturates at 0xFFFF and clears on Peak_req with Peak_index=0.
- Macro undefined: Sat_count is tied to 0 and no counter logic is built.

Test Plan:
- Defaults, mode 0: I=3000, Q=-4000 -> Output_data=5125 exactly 3 cycles after input. Modes 1/2/3 give 5500/4750/5000.
- Mode 0, I=-8192, Q=0 -> 8191, Output_saturated=0. Mode 3, I=100, Q=0 -> 100.
- OUTPUT_WIDTH=13, mode 1, I=Q=8191 -> 8191, Output_saturated=1. With macro: Sat_count=1, and 70000 such samples -> 0xFFFF.
- LATENCY=6, random mode/index every cycle with random gaps, 10000 samples -> every output matches the model 6 cycles later with correct Output_index.
- Channel 2 fed 500, 900, 300, then Peak_req idx 2 -> 900. Second read -> 0. Read coinciding with an Output_valid of 700 on channel 2 -> returns prior peak, and the next read returns 700.
- Rst_n pulsed low with 2 samples in flight -> no Output_valid. Next input after release -> output LATENCY cycles later, all peaks 0.
